// File: rtl/ul4_pkg.sv
// ----------------------------------------------------------------------------
// ul4_pkg
// Shared definitions for the ul4 logic unit and its two-requester arbiter:
//   - UL4_W        : operand / result width (4 bits)
//   - UL4_AND..NOT : function-select encodings for the ul4
//   - ul4_state_e  : arbiter FSM states (IDLE, EXEC, HOLD)
// ----------------------------------------------------------------------------
package ul4_pkg;

  localparam int UL4_W = 4;

  localparam logic [1:0] UL4_AND = 2'b00;
  localparam logic [1:0] UL4_OR  = 2'b01;
  localparam logic [1:0] UL4_XOR = 2'b10;
  localparam logic [1:0] UL4_NOT = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    HOLD = 2'b10
  } ul4_state_e;

endpackage

// File: rtl/ul4.sv
// ----------------------------------------------------------------------------
// ul4
// Purely combinational 4-bit logic unit.
// Ports:
//   a, b : operands
//   s    : function select (AND / OR / XOR / NOT a)
//   y    : result
// ----------------------------------------------------------------------------
module ul4
  import ul4_pkg::*;
(
  input  logic [UL4_W-1:0] a,
  input  logic [UL4_W-1:0] b,
  input  logic [1:0]       s,
  output logic [UL4_W-1:0] y
);

  // Function decode
  always_comb begin
    y = {UL4_W{1'b0}};
    case (s)
      UL4_AND: y = a & b;
      UL4_OR:  y = a | b;
      UL4_XOR: y = a ^ b;
      UL4_NOT: y = ~a;
      default: y = {UL4_W{1'b0}};
    endcase
  end

endmodule

// File: rtl/ul4_rr_pick.sv
// ----------------------------------------------------------------------------
// ul4_rr_pick
// Combinational grant selection between two requesters.
// Default build: round-robin, a tie goes to the requester that was not
// granted last. With UL4_ARB_FIXED_PRIO_EN defined: fixed priority,
// requester 0 always wins ties and last_grant is ignored.
// Ports:
//   valid0, valid1 : request valids
//   last_grant     : id of the most recently granted requester
//   grant_valid    : at least one requester is valid
//   grant_id       : id of the selected requester
// ----------------------------------------------------------------------------
module ul4_rr_pick (
  input  logic valid0,
  input  logic valid1,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_id
);

`ifdef UL4_ARB_FIXED_PRIO_EN
  // last_grant is intentionally ignored in fixed-priority mode
  logic unused_last_grant_s;
  assign unused_last_grant_s = last_grant;

  // Fixed priority: requester 0 first
  always_comb begin
    grant_valid = valid0 | valid1;
    if (valid0) begin
      grant_id = 1'b0;
    end else begin
      grant_id = valid1;
    end
  end
`else
  // Round-robin: on a tie the requester not granted last wins
  always_comb begin
    grant_valid = valid0 | valid1;
    if (valid0 && valid1) begin
      grant_id = ~last_grant;
    end else begin
      grant_id = valid1;
    end
  end
`endif

endmodule

// File: rtl/ul4_arbiter.sv
// ----------------------------------------------------------------------------
// ul4_arbiter
// Shares one ul4 logic unit between two requesters. A request is accepted in
// IDLE via valid/ready, its operands are latched, the ul4 result is registered
// in EXEC and held in HOLD until the consumer takes it.
// Optional feature macro: UL4_ARB_FIXED_PRIO_EN (fixed priority, see
// ul4_rr_pick).
// Parameters:
//   RESET_LAST : requester treated as last granted after reset
// Ports:
//   clk, reset                  : clock, async active-high reset
//   req0_* / req1_*             : requester valid/ready/a/b/s
//   rsp_valid, rsp_ready        : response handshake
//   rsp_out, rsp_id             : registered result and originating requester
// ----------------------------------------------------------------------------
module ul4_arbiter
  import ul4_pkg::*;
#(
  parameter bit RESET_LAST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [UL4_W-1:0] req0_a,
  input  logic [UL4_W-1:0] req0_b,
  input  logic [1:0]       req0_s,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [UL4_W-1:0] req1_a,
  input  logic [UL4_W-1:0] req1_b,
  input  logic [1:0]       req1_s,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [UL4_W-1:0] rsp_out,
  output logic             rsp_id
);

  ul4_state_e       state_r;
  ul4_state_e       state_nxt_s;
  logic             last_grant_r;
  logic             grant_valid_s;
  logic             grant_id_s;
  logic             accept_s;
  logic [UL4_W-1:0] op_a_r;
  logic [UL4_W-1:0] op_b_r;
  logic [1:0]       op_s_r;
  logic             op_id_r;
  logic [UL4_W-1:0] ul4_y_s;
  logic [UL4_W-1:0] rsp_out_r;
  logic             rsp_id_r;
  logic             rsp_valid_r;

  ul4_rr_pick u_pick (
    .valid0      (req0_valid),
    .valid1      (req1_valid),
    .last_grant  (last_grant_r),
    .grant_valid (grant_valid_s),
    .grant_id    (grant_id_s)
  );

  // The shared unit only ever sees the latched operands
  ul4 u_ul4 (
    .a (op_a_r),
    .b (op_b_r),
    .s (op_s_r),
    .y (ul4_y_s)
  );

  // Next-state and acceptance decode
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    case (state_r)
      IDLE: begin
        // Gating with reset keeps both readies low while reset is held
        if (grant_valid_s && !reset) begin
          accept_s    = 1'b1;
          state_nxt_s = EXEC;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      EXEC: state_nxt_s = HOLD;
      HOLD: begin
        if (rsp_valid_r && rsp_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Ready goes only to the granted requester, in the accepting cycle
  always_comb begin
    req0_ready = accept_s & (grant_id_s == 1'b0);
    req1_ready = accept_s & (grant_id_s == 1'b1);
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Arbitration history, updated on every accepted request
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_r <= RESET_LAST;
    end else if (accept_s) begin
      last_grant_r <= grant_id_s;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end

  // Operand latch for the winning requester
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_a_r  <= {UL4_W{1'b0}};
      op_b_r  <= {UL4_W{1'b0}};
      op_s_r  <= 2'b00;
      op_id_r <= 1'b0;
    end else if (accept_s) begin
      op_id_r <= grant_id_s;
      if (grant_id_s) begin
        op_a_r <= req1_a;
        op_b_r <= req1_b;
        op_s_r <= req1_s;
      end else begin
        op_a_r <= req0_a;
        op_b_r <= req0_b;
        op_s_r <= req0_s;
      end
    end else begin
      op_a_r  <= op_a_r;
      op_b_r  <= op_b_r;
      op_s_r  <= op_s_r;
      op_id_r <= op_id_r;
    end
  end

  // Response registers: loaded in EXEC, cleared valid on consumer handshake.
  // rsp_out/rsp_id keep their last value once the response is consumed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_out_r   <= {UL4_W{1'b0}};
      rsp_id_r    <= 1'b0;
      rsp_valid_r <= 1'b0;
    end else if (state_r == EXEC) begin
      rsp_out_r   <= ul4_y_s;
      rsp_id_r    <= op_id_r;
      rsp_valid_r <= 1'b1;
    end else if ((state_r == HOLD) && rsp_valid_r && rsp_ready) begin
      rsp_valid_r <= 1'b0;
    end else begin
      rsp_out_r   <= rsp_out_r;
      rsp_id_r    <= rsp_id_r;
      rsp_valid_r <= rsp_valid_r;
    end
  end

  assign rsp_valid = rsp_valid_r;
  assign rsp_out   = rsp_out_r;
  assign rsp_id    = rsp_id_r;

endmodule

// File: doc/ul4_arbiter.md
# ul4_arbiter

Shares a single `ul4` 4-bit logic unit between two requesters. Each requester presents operands `a`, `b` and a 2-bit function select over a valid/ready handshake. The block arbitrates round-robin, latches the winner's operation and drives the shared `ul4`. It returns the registered 4-bit result with the originating requester id over a valid/ready response channel.

## Interface
- `RESET_LAST`, default 1: requester treated as "last granted" after reset, so requester 0 wins the first tie.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req0_valid`  in  1  requester 0 has an operation.
- `req0_ready`  out  1  requester 0 operation accepted this cycle.
- `req0_a`  in  4  requester 0 operand a.
- `req0_b`  in  4  requester 0 operand b.
- `req0_s`  in  2  requester 0 function select.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_s`: same as requester 0, for requester 1.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer accepts result.
- `rsp_out`  out  4  result.
- `rsp_id`  out  1  requester that issued the result.

## Operation
- Function select encoding:
  - 00 = a AND b
  - 01 = a OR b
  - 10 = a XOR b
  - 11 = NOT a
- FSM states are IDLE, EXEC and HOLD. Reset state is IDLE.
- IDLE:
  - If exactly one `reqX_valid` is high, that requester is granted.
  - If both are high, the requester that is not `last_grant` is granted.
  - The granted requester's `reqX_ready` is asserted combinationally in the same cycle. The other ready stays 0.
  - On the handshake, `a`, `b`, `s` and the id are latched, `last_grant` is updated, and the FSM moves to EXEC.
  - If no requester is valid, the FSM stays in IDLE with both readies at 0.
- EXEC:
  - The `ul4` is driven only from the latched operands, never from live request inputs.
  - Its output is registered into `rsp_out`, the id goes to `rsp_id`, and `rsp_valid` is set to 1.
  - The FSM moves to HOLD.
- HOLD:
  - `rsp_out`, `rsp_id` and `rsp_valid` are held stable.
  - On `rsp_valid && rsp_ready`, `rsp_valid` clears and the FSM moves to IDLE.
  - Both `reqX_ready` stay 0 in EXEC and HOLD.
- Requester inputs may change freely after their handshake; the latched copy is unaffected.

## Timing
- Reset values:
  - `req0_ready`, `req1_ready`, `rsp_valid`, `rsp_out`, `rsp_id` = 0
  - state = IDLE
  - `last_grant` = `RESET_LAST`
- Latency: a request accepted on edge N gives `rsp_valid` = 1 after edge N+1.
- Throughput: at most one operation per 3 cycles when `rsp_ready` is held at 1.
- A requester that holds `valid` is guaranteed a grant within 2 arbitration rounds under contention.
- Reset asserted mid-operation (EXEC or HOLD):
  - Outputs clear immediately, without waiting for a clock edge.
  - The in-flight result is discarded and never presented.
- A `valid` that drops in IDLE before its handshake is not an accepted operation. No state changes.

## Configuration
- `UL4_ARB_FIXED_PRIO_EN`:
  - Defined: fixed priority, requester 0 always wins ties. `last_grant` and `RESET_LAST` have no effect.
  - Undefined: round-robin as specified above.

## Structure
- Package `ul4_pkg` holds:
  - the FSM state enum (IDLE/EXEC/HOLD)
  - function-select constants `UL4_AND`, `UL4_OR`, `UL4_XOR`, `UL4_NOT`
  - the operand width constant 4
- Sub-module `ul4_rr_pick` is purely combinational. It takes both valids and `last_grant`, and returns `grant_valid` and `grant_id`. The fixed-priority variant is selected inside it by the macro.
- The `ul4` itself is instantiated once, unchanged, inside `ul4_arbiter`.

## Test plan
- Single request: req0 a=1100, b=1010, s=00, `rsp_ready`=1 → `req0_ready` pulses 1 cycle; `rsp_out`=1000, `rsp_id`=0 one cycle after accept.
- All functions: req1 a=0110, b=0011 with s=00/01/10/11 → results 0010/0111/0101/1001, `rsp_id`=1 each time.
- Contention after reset, both valid continuously, `rsp_ready`=1 → grants alternate 0,1,0,1.
  - With `UL4_ARB_FIXED_PRIO_EN` defined: 0,0,0,0.
- Backpressure: `rsp_ready`=0 for 5 cycles after `rsp_valid` → `rsp_out` and `rsp_id` are stable, both readies stay 0, and the request inputs may change without effect. Raising `rsp_ready` gives one handshake, then a return to IDLE.
- Reset asserted during HOLD with `rsp_valid`=1 → `rsp_valid` drops immediately. After release, the first tie grants requester 0.
- Idle: no valids for 10 cycles → readies and `rsp_valid` stay 0, and `rsp_out` keeps its last value.
